// File: rtl/wait_state_ram.sv
// wait_state_ram: word-organised data memory for the rv32i data port that
// stretches every load and store over a programmable number of busy cycles,
// so the core's rbusy/wbusy stall paths actually get exercised.
module wait_state_ram #(
  parameter int    ADDR_BITS  = 10,
  parameter int    READ_WAIT  = 2,
  parameter int    WRITE_WAIT = 1,
  parameter string INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [3:0]  wmask,
  input  logic        rstrb,
  input  logic        wstrb,
  output logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic        rbusy,
  output logic        wbusy
);

  localparam int DEPTH = 1 << ADDR_BITS;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RD_WAIT = 2'd1;
  localparam logic [1:0] S_WR_WAIT = 2'd2;

  // Counter reload values; the counter expires on the edge where it reads 0,
  // so a wait of N cycles loads N-1.
  localparam logic [3:0] RD_LOAD = (READ_WAIT  > 0) ? 4'(READ_WAIT  - 1) : 4'd0;
  localparam logic [3:0] WR_LOAD = (WRITE_WAIT > 0) ? 4'(WRITE_WAIT - 1) : 4'd0;

  logic [31:0] mem_q [DEPTH];

  logic [1:0]           state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [ADDR_BITS-1:0] idx_q, idx_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [3:0]           wmask_q, wmask_d;
  logic                 rbusy_q, rbusy_d;
  logic                 wbusy_q, wbusy_d;
  logic [31:0]          rdata_q;

  // Array port controls for this cycle.
  logic                 wr_en;
  logic [ADDR_BITS-1:0] wr_idx;
  logic [31:0]          wr_data;
  logic [3:0]           wr_mask;
  logic                 rd_en;
  logic [ADDR_BITS-1:0] rd_idx;

  // Byte offset and high address bits are don't-care: addresses alias.
  logic [ADDR_BITS-1:0] addr_idx;
  logic                 unused_addr_bits;
  assign addr_idx         = addr[ADDR_BITS+1:2];
  assign unused_addr_bits = ^{addr[31:ADDR_BITS+2], addr[1:0]};

  // Next-state logic: accept strobes only in IDLE, count down wait states.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    rbusy_d = rbusy_q;
    wbusy_d = wbusy_q;
    wr_en   = 1'b0;
    wr_idx  = idx_q;
    wr_data = wdata_q;
    wr_mask = wmask_q;
    rd_en   = 1'b0;
    rd_idx  = idx_q;
    case (state_q)
      S_IDLE: begin
        if (wstrb) begin
          // A write takes priority; a simultaneous read strobe is dropped.
          idx_d   = addr_idx;
          wdata_d = wdata;
          wmask_d = wmask;
          if (WRITE_WAIT == 0) begin
            wr_en   = 1'b1;
            wr_idx  = addr_idx;
            wr_data = wdata;
            wr_mask = wmask;
          end else begin
            wbusy_d = 1'b1;
            cnt_d   = WR_LOAD;
            state_d = S_WR_WAIT;
          end
        end else if (rstrb) begin
          idx_d = addr_idx;
          if (READ_WAIT == 0) begin
            rd_en  = 1'b1;
            rd_idx = addr_idx;
          end else begin
            rbusy_d = 1'b1;
            cnt_d   = RD_LOAD;
            state_d = S_RD_WAIT;
          end
        end
      end
      S_RD_WAIT: begin
        // The array is sampled at completion, so a read sees the latest data.
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          rd_en   = 1'b1;
          rbusy_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_WR_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          wr_en   = 1'b1;
          wbusy_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
        rbusy_d = 1'b0;
        wbusy_d = 1'b0;
      end
    endcase
  end

  // Control state; reset abandons any pending access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      wmask_q <= 4'd0;
      rbusy_q <= 1'b0;
      wbusy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      rbusy_q <= rbusy_d;
      wbusy_q <= wbusy_d;
    end
  end

  // Read data register: only loaded by a completing read, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= 32'd0;
    end else if (rd_en) begin
      rdata_q <= mem_q[rd_idx];
    end
  end

  // Byte-lane write port; the array is never reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_mask[i]) begin
          mem_q[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  assign rdata = rdata_q;
  assign rbusy = rbusy_q;
  assign wbusy = wbusy_q;

endmodule

// File: tb/tb_wait_state_ram.sv
// Directed bench for wait_state_ram: a vector table of reads/writes against
// the default configuration plus hand sequences for collisions and resets,
// including a second instance with WRITE_WAIT=3.
module tb_wait_state_ram;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [3:0]  wmask = 4'd0;
  logic        rstrb = 1'b0, wstrb = 1'b0;
  logic        rstrb3 = 1'b0, wstrb3 = 1'b0;
  logic [31:0] rdata, rdata3;
  logic        rbusy, wbusy, rbusy3, wbusy3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wait_state_ram dut (
    .clk(clk), .rst(rst), .addr(addr), .wmask(wmask), .rstrb(rstrb),
    .wstrb(wstrb), .rdata(rdata), .wdata(wdata), .rbusy(rbusy), .wbusy(wbusy)
  );

  wait_state_ram #(.WRITE_WAIT(3)) dut3 (
    .clk(clk), .rst(rst), .addr(addr), .wmask(wmask), .rstrb(rstrb3),
    .wstrb(wstrb3), .rdata(rdata3), .wdata(wdata), .rbusy(rbusy3), .wbusy(wbusy3)
  );

  typedef struct {
    bit          is_wr;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  m;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic cur_busy(input bit sel, input bit is_wr);
    if (sel) return is_wr ? wbusy3 : rbusy3;
    return is_wr ? wbusy : rbusy;
  endfunction

  // One strobe, then count cycles until the matching busy drops (bounded).
  task automatic access(input bit sel, input bit is_wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] m, output int cycles);
    @(negedge clk);
    addr = a; wdata = d; wmask = m;
    if (sel) begin wstrb3 = is_wr; rstrb3 = !is_wr; end
    else     begin wstrb  = is_wr; rstrb  = !is_wr; end
    @(posedge clk); #1;
    wstrb = 1'b0; rstrb = 1'b0; wstrb3 = 1'b0; rstrb3 = 1'b0;
    cycles = 0;
    while (cur_busy(sel, is_wr) && cycles < 40) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  initial begin
    int cyc;
    logic [31:0] last_rd;

    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 32'h0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         4'b0000, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 32'h0000_0000, 32'h1122_3344, 4'b1111, 32'h0};
    vecs[3]  = '{1'b1, 32'h0000_0002, 32'hAABB_CCDD, 4'b0101, 32'h0};
    vecs[4]  = '{1'b0, 32'h0000_0000, 32'h0,         4'b0000, 32'h11BB_33DD};
    vecs[5]  = '{1'b1, 32'h0000_1004, 32'hCAFE_F00D, 4'b1111, 32'h0};
    vecs[6]  = '{1'b0, 32'h0000_0004, 32'h0,         4'b0000, 32'hCAFE_F00D};
    vecs[7]  = '{1'b1, 32'h0000_0008, 32'h55AA_55AA, 4'b1111, 32'h0};
    vecs[8]  = '{1'b1, 32'h0000_0008, 32'h1234_5678, 4'b0000, 32'h0};
    vecs[9]  = '{1'b0, 32'h0000_0008, 32'h0,         4'b0000, 32'h55AA_55AA};
    vecs[10] = '{1'b0, 32'h0000_0013, 32'h0,         4'b0000, 32'hDEAD_BEEF};
    vecs[11] = '{1'b1, 32'h0000_000C, 32'h0000_0000, 4'b1111, 32'h0};
    vecs[12] = '{1'b1, 32'h0000_000C, 32'hFFFF_FFFF, 4'b1000, 32'h0};
    vecs[13] = '{1'b0, 32'h0000_000C, 32'h0,         4'b0000, 32'hFF00_0000};
    vecs[14] = '{1'b0, 32'hFFFF_F010, 32'h0,         4'b0000, 32'hDEAD_BEEF};
    vecs[15] = '{1'b0, 32'h0000_0000, 32'h0,         4'b0000, 32'h11BB_33DD};

    // Power-on reset state.
    #2;
    check("por_rdata", rdata, 32'h0);
    check("por_rbusy", {31'd0, rbusy}, 32'h0);
    check("por_wbusy", {31'd0, wbusy}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Table-driven reads and writes.
    last_rd = 32'h0;
    for (int i = 0; i < 16; i++) begin
      access(1'b0, vecs[i].is_wr, vecs[i].a, vecs[i].d, vecs[i].m, cyc);
      check(vecs[i].is_wr ? "wr_wait_cycles" : "rd_wait_cycles", cyc,
            vecs[i].is_wr ? 32'd1 : 32'd2);
      if (!vecs[i].is_wr) begin
        check("rd_data", rdata, vecs[i].exp);
        last_rd = vecs[i].exp;
      end
      $display("vec %0d %s addr=%h wdata=%h wmask=%b cycles=%0d rdata=%h",
               i, vecs[i].is_wr ? "WR" : "RD", vecs[i].a, vecs[i].d, vecs[i].m, cyc, rdata);
    end

    // Collision: write wins, then a read strobe during WR_WAIT is ignored.
    @(negedge clk);
    addr = 32'h14; wdata = 32'h0BAD_F00D; wmask = 4'b1111; wstrb = 1'b1; rstrb = 1'b1;
    @(posedge clk); #1;
    wstrb = 1'b0; rstrb = 1'b0;
    check("coll_wbusy", {31'd0, wbusy}, 32'h1);
    check("coll_rbusy", {31'd0, rbusy}, 32'h0);
    @(negedge clk);
    addr = 32'h10; rstrb = 1'b1;
    @(posedge clk); #1;
    rstrb = 1'b0;
    check("ign_wbusy_done", {31'd0, wbusy}, 32'h0);
    check("ign_rbusy", {31'd0, rbusy}, 32'h0);
    @(posedge clk); #1;
    check("ign_rbusy_later", {31'd0, rbusy}, 32'h0);
    check("ign_rdata_held", rdata, last_rd);
    access(1'b0, 1'b0, 32'h14, 32'h0, 4'b0, cyc);
    check("coll_commit", rdata, 32'h0BAD_F00D);
    $display("collision write addr=14 readback=%h", rdata);

    // Asynchronous reset in the middle of a read.
    @(negedge clk);
    addr = 32'h4; rstrb = 1'b1;
    @(posedge clk); #1;
    rstrb = 1'b0;
    check("midrd_rbusy", {31'd0, rbusy}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_rdata", rdata, 32'h0);
    check("arst_rbusy", {31'd0, rbusy}, 32'h0);
    check("arst_wbusy", {31'd0, wbusy}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("dropped_read", rdata, 32'h0);
    access(1'b0, 1'b0, 32'h10, 32'h0, 4'b0, cyc);
    check("mem_kept", rdata, 32'hDEAD_BEEF);
    $display("reset mid-read, preserved readback=%h", rdata);

    // WRITE_WAIT=3 instance: latency, then reset mid-write drops the write.
    access(1'b1, 1'b1, 32'h20, 32'h0, 4'b1111, cyc);
    check("ww3_cycles", cyc, 32'd3);
    access(1'b1, 1'b1, 32'h24, 32'h1357_2468, 4'b1111, cyc);
    $display("ww3 init writes done cycles=%0d", cyc);
    @(negedge clk);
    addr = 32'h20; wdata = 32'hFFFF_FFFF; wmask = 4'b1111; wstrb3 = 1'b1;
    @(posedge clk); #1;
    wstrb3 = 1'b0;
    check("ww3_wbusy", {31'd0, wbusy3}, 32'h1);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("ww3_arst_wbusy", {31'd0, wbusy3}, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    access(1'b1, 1'b0, 32'h24, 32'h0, 4'b0, cyc);
    check("ww3_rd_other", rdata3, 32'h1357_2468);
    access(1'b1, 1'b0, 32'h20, 32'h0, 4'b0, cyc);
    check("ww3_rd_cycles", cyc, 32'd2);
    check("ww3_dropped_write", rdata3, 32'h0);
    $display("reset mid-write, readback addr=20 %h", rdata3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
